// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes A - B - borrow_in one bit per clock, LSB
// first, through a single full-subtractor cell and a borrow flip-flop.
// Start/busy/done handshake; result, borrow-out and signed overflow are held
// until the next completion.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B,
  output logic             oOverflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             diff_bit;
  logic             br_next;
  logic             load;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    data_d   = data_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        load = iStart;
      end
      SHIFT: begin
        br_d   = br_next;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = {diff_bit, d_sh_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          data_d   = {diff_bit, d_sh_q[WIDTH-1:1]};
          borrow_d = br_next;
          ovf_d    = (sign_a_q != sign_b_q) && (diff_bit != sign_a_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        // The edge leaving DONE doubles as the earliest start edge, giving
        // back-to-back results every WIDTH+1 cycles.
        load    = iStart;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_sh_d   = iData_a;
      b_sh_d   = iData_b;
      br_d     = iB;
      cnt_d    = '0;
      sign_a_d = iData_a[WIDTH-1];
      sign_b_d = iData_b[WIDTH-1];
      state_d  = SHIFT;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      data_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      data_q   <= data_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    oBusy     = (state_q != IDLE);
    oDone     = (state_q == DONE);
    oData     = data_q;
    oData_B   = borrow_q;
    oOverflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] da;
  logic [7:0] db;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       bout;
  logic       ovf;

  int unsigned vectors;
  int unsigned errors;

  serial_sub #(.WIDTH(8)) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iStart   (start),
    .iData_a  (da),
    .iData_b  (db),
    .iB       (bin),
    .oBusy    (busy),
    .oDone    (done),
    .oData    (dout),
    .oData_B  (bout),
    .oOverflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with cycle-accurate handshake checks.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] exp_d, input logic exp_b,
                        input logic exp_o);
    logic [7:0] prev;
    prev  = dout;
    da    = a;
    db    = b;
    bin   = bi;
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    da    = 8'hC3;                // don't-care after acceptance
    db    = 8'h3C;
    bin   = 1'b1;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_E0 busy=%b done=%b want busy=1 done=0", nm, busy, done);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || dout !== prev) begin
        errors++;
        $display("FAIL %s_E%0d busy=%b done=%b data=%h want busy=1 done=0 data=%h",
                 nm, i, busy, done, dout, prev);
      end
    end
    tick();                       // E8
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || dout !== exp_d || bout !== exp_b || ovf !== exp_o) begin
      errors++;
      $display("FAIL %s_E8 done=%b busy=%b data=%h B=%b ovf=%b want done=1 busy=1 data=%h B=%b ovf=%b",
               nm, done, busy, dout, bout, ovf, exp_d, exp_b, exp_o);
    end
    tick();                       // E9
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== exp_d) begin
      errors++;
      $display("FAIL %s_E9 busy=%b done=%b data=%h want busy=0 done=0 data=%h",
               nm, busy, done, dout, exp_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    da = '0; db = '0; bin = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b data=%h B=%b ovf=%b want all zero",
               busy, done, dout, bout, ovf);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_borrow();
    run_op("borrow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_borrow_in();
    run_op("ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("max", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // iStart held high; operands scrambled mid-SHIFT and restored in DONE.
  task automatic test_back_to_back();
    logic [7:0] prev;
    logic       exp_done;
    prev  = dout;
    da    = 8'h10;
    db    = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    tick();                       // E0
    da = 8'hEE; db = 8'h99;
    for (int c = 1; c <= 27; c++) begin
      tick();
      exp_done = (c == 8 || c == 17 || c == 26);
      vectors++;
      if (done !== exp_done || busy !== (c <= 26)) begin
        errors++;
        $display("FAIL b2b_hs_c%0d done=%b busy=%b want done=%b busy=%b",
                 c, done, busy, exp_done, (c <= 26));
      end
      vectors++;
      if (c < 8) begin
        if (dout !== prev) begin
          errors++;
          $display("FAIL b2b_hold_c%0d data=%h want %h", c, dout, prev);
        end
      end else if (dout !== 8'h0F || bout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL b2b_data_c%0d data=%h B=%b ovf=%b want 0f 0 0", c, dout, bout, ovf);
      end
      if (c == 8 || c == 17) begin
        da = 8'h10; db = 8'h01;
      end else begin
        da = 8'(8'hEE - c); db = 8'(8'h99 + c);
      end
      if (c == 26) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op();
    da    = 8'hAA;
    db    = 8'h55;
    bin   = 1'b0;
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick(); tick(); tick();       // E1..E3
    rst_n = 1'b0;
    tick();                       // E4 with reset
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst busy=%b done=%b data=%h B=%b ovf=%b want all zero",
               busy, done, dout, bout, ovf);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet_%0d done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    run_op("after_rst", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
  endtask

  // Operand sweep over corner-heavy values against an arithmetic model.
  task automatic test_sweep();
    logic [7:0] vals [12];
    logic [8:0] ref9;
    logic [7:0] a, b, r;
    logic       o;
    int         waited;
    vals = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h55, 8'h7E, 8'h7F,
             8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 12; j++) begin
        for (int k = 0; k < 2; k++) begin
          a = vals[i];
          b = vals[j];
          ref9 = {1'b0, a} - {1'b0, b} - 9'(k);
          r = ref9[7:0];
          o = (a[7] != b[7]) && (r[7] != a[7]);
          da = a; db = b; bin = k[0]; start = 1'b1;
          tick();
          start = 1'b0;
          waited = 0;
          while (done !== 1'b1 && waited < 20) begin
            tick();
            waited++;
          end
          vectors++;
          if (done !== 1'b1 || waited != 8 || dout !== r || bout !== ref9[8] || ovf !== o) begin
            errors++;
            $display("FAIL sweep a=%h b=%h bi=%0d cyc=%0d data=%h B=%b ovf=%b want cyc=8 data=%h B=%b ovf=%b",
                     a, b, k, waited, dout, bout, ovf, r, ref9[8], o);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow_borrow_in();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
